// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - period and high-time meter for an asynchronous square wave (option macro: CLK_PERIOD_METER_DUTY_EN)
module clk_period_meter #(
    parameter int unsigned  W       = 28,
    parameter logic [W-1:0] TIMEOUT = W'(2000000)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         timeout
);

    typedef enum logic {
        ST_ARM  = 1'b0,
        ST_MEAS = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic         s1_q, s2_q, s3_q;
    logic         rise;
    logic [W-1:0] per_cnt_q, per_cnt_d;
    logic [W-1:0] period_q, period_d;
    logic         valid_q, valid_d;
    logic         timeout_q, timeout_d;

    // Three-flop chain: s1/s2 resolve metastability, s3 remembers the previous level for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    // Next state: the first rise only arms (partial cycle), later rises publish the running count.
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            ST_ARM: begin
                if (rise) begin
                    state_d   = ST_MEAS;
                    per_cnt_d = W'(1);
                end
            end
            ST_MEAS: begin
                // A rise landing on the TIMEOUT count still counts as a measurement.
                if (rise) begin
                    period_d  = per_cnt_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    per_cnt_d = W'(1);
                end else if (per_cnt_q == TIMEOUT) begin
                    state_d   = ST_ARM;
                    timeout_d = 1'b1;
                    per_cnt_d = '0;
                end else begin
                    per_cnt_d = per_cnt_q + W'(1);
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    // State, period counter and published results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_ARM;
            per_cnt_q <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef CLK_PERIOD_METER_DUTY_EN
    logic [W-1:0] hi_cnt_q, hi_cnt_d;
    logic [W-1:0] high_time_q, high_time_d;

    // High-time counter follows the period counter's restart points, counting only while s2 is high.
    always_comb begin
        hi_cnt_d    = hi_cnt_q;
        high_time_d = high_time_q;
        if (rise) begin
            hi_cnt_d = W'(1);
            if (state_q == ST_MEAS) begin
                high_time_d = hi_cnt_q;
            end
        end else if (state_q == ST_MEAS) begin
            if (per_cnt_q == TIMEOUT) begin
                hi_cnt_d = '0;
            end else if (s2_q) begin
                hi_cnt_d = hi_cnt_q + W'(1);
            end
        end
    end

    // High-time counter and published high time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_cnt_q    <= '0;
            high_time_q <= '0;
        end else begin
            hi_cnt_q    <= hi_cnt_d;
            high_time_q <= high_time_d;
        end
    end

    assign high_time = high_time_q;
`else
    assign high_time = '0;
`endif

    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule
